wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the single-issue RV32I core. It sits directly upstream of the register file write port. It accepts retiring instructions from the MEM stage and completions from the multi-cycle mul/div unit, and arbitrates between them. It aligns and extends load data, selects the writeback value, and drives a registered `wb_we/wb_rd/wb_wdata` triple. Decode uses the same triple as its forwarding source, because register file reads do not bypass same-cycle writes.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  MEM-stage entry valid
- in_ready  out  1  entry accepted this cycle
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register
- in_wb_sel  in  2  0=ALU, 1=LOAD, 2=PC+4, 3=ALU
- in_alu_result  in  32  ALU result; also the load address
- in_pc  in  32  instruction PC
- in_load_data  in  32  raw aligned memory word
- in_funct3  in  3  load type
- md_valid  in  1  mul/div result valid
- md_ready  out  1  mul/div result accepted this cycle
- md_rd  in  5  mul/div destination
- md_result  in  32  mul/div result
- wb_we  out  1  register file write enable (registered)
- wb_rd  out  5  register file write address (registered)
- wb_wdata  out  32  register file write data (registered)
- misalign_err  out  1  one-cycle pulse: misaligned load dropped
- instret  out  64  retired-instruction count (only with WB_INSTRET_EN)

## Operation
- Arbitration:
  - The state bit `md_last` resets to 0.
  - The mul/div source wins when `md_valid && !(md_last && in_valid)`.
  - Otherwise the pipeline source wins when `in_valid`.
  - `in_ready` and `md_ready` are combinational grants and are mutually exclusive.
  - Both grants are forced to 0 while `rst` is high.
  - `md_last` takes the value "mul/div granted" on every cycle that has a grant. It holds when there is no grant.
- Stage register S (valid, we, rd, data):
  - On a grant, S loads from the winning source.
  - With no grant, `S.valid` goes to 0.
- Mul/div entry: `we = (md_rd != 0)`, `data = md_result`.
- Pipeline entry: `we = in_reg_write && in_rd != 0 && !misaligned`. Data by `in_wb_sel`:
  - ALU or 3: `in_alu_result`.
  - PC+4: `in_pc + 4`, modulo 2^32.
  - LOAD: aligned value as below.
- Load alignment:
  - The offset is `in_alu_result[1:0]`.
  - The word is shifted right by 8×offset.
  - LB (000) and LH (001) sign-extend from bit 7 and bit 15 respectively.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes the word unchanged. Undefined funct3 values are treated as LW.
- Misalignment:
  - Defined as LH/LHU with odd offset, or LW (including undefined funct3) with nonzero offset, and only when `in_wb_sel`=LOAD.
  - The write is suppressed.
  - `misalign_err` pulses for exactly one cycle, aligned with the cycle the entry would have written.
- Outputs:
  - `wb_we = S.valid && S.we`.
  - `wb_rd` and `wb_wdata` follow S. Their values are don't-care when `wb_we` is 0, but they must be deterministic.
- A write to x0 is never issued, from either source.

## Timing
- Latency is 1 cycle. An entry granted at edge N drives `wb_*` from edge N until edge N+1. The register file commits it at edge N+1.
- Throughput is one write per cycle.
- When both sources are continuously valid, grants strictly alternate. No source waits more than one cycle.
- Reset values: S.valid=0, S.we=0, S.rd=0, S.data=0, `md_last`=0, `misalign_err`=0, `instret`=0.
  - Reset takes effect immediately and asynchronously.
  - An entry in flight when reset asserts is discarded and never written.
- First grant after deassertion: on the first edge with `rst` low, the grant follows the arbitration rules with `md_last`=0.

## Configuration
- `WB_INSTRET_EN` defined:
  - A 64-bit `instret` counter is present.
  - It increments by 1 on every pipeline grant, including non-writing and misaligned entries.
  - It does not increment on mul/div grants.
  - It wraps to 0 after 2^64−1.
- `WB_INSTRET_EN` undefined: the `instret` port and the counter are absent.

## Structure
- Package `wb_pkg` holds:
  - `wb_sel_t` enum: WB_ALU, WB_LOAD, WB_PC4.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- One combinational sub-module `load_align`, with inputs word, offset and funct3, and outputs data and misaligned.
- The arbiter and stage register are implemented in `wb_stage` itself.

## Test plan
- LB, offset 3, `in_load_data`=0x80FF_1234, rd=5 → next cycle `wb_we`=1, `wb_rd`=5, `wb_wdata`=0xFFFF_FF80.
- LHU, offset 2, data 0xBEEF_0000 → `wb_wdata`=0x0000_BEEF. LH at offset 1 → `wb_we`=0, `misalign_err`=1 for exactly one cycle.
- ALU 0x1234 with rd=0 and `in_reg_write`=1 → `wb_we`=0. PC+4 with pc=0xFFFF_FFFC, rd=1 → `wb_wdata`=0x0000_0000.
- `md_valid` and `in_valid` both high for 4 cycles from reset → grants are md, pipe, md, pipe. `in_ready` is 0, 1, 0, 1. With WB_INSTRET_EN, `instret`=2.
- Assert `rst` mid-cycle while S holds a valid write → `wb_we` drops to 0 immediately. After release, the next grant follows the arbitration rules with `md_last`=0.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the writeback stage.
//   XLEN      : datapath width (32 only)
//   wb_sel_t  : writeback value select (encoding 3 behaves as WB_ALU)
//   F3_*      : load funct3 encodings
//   stage_t   : contents of the writeback stage register
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } stage_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load data alignment and extension.
//   word       in  raw aligned memory word
//   offset     in  byte offset within the word (load address [1:0])
//   funct3     in  load type; undefined encodings behave as LW
//   data       out shifted and sign/zero-extended load value
//   misaligned out access is not naturally aligned for its size
// -----------------------------------------------------------------------------
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU: data = {24'd0, shifted[7:0]};
            F3_LH: begin
                data       = {{16{shifted[15]}}, shifted[15:0]};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'd0, shifted[15:0]};
                misaligned = offset[0];
            end
            default: begin
                // LW and every undefined encoding: whole word, must be aligned.
                data       = word;
                misaligned = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage: arbitrates between retiring MEM-stage entries and mul/div
// completions, aligns load data, and registers the register-file write triple
// (also used by decode as its forwarding source).
//
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction
// counter on port instret (pipeline grants only).
//
// Ports
//   clk, rst (async, active-high)
//   in_*          MEM-stage entry; in_ready is its combinational grant
//   md_*          mul/div completion; md_ready is its combinational grant
//   wb_we/wb_rd/wb_wdata  registered register-file write
//   misalign_err  one-cycle pulse when a misaligned load is dropped
//   instret       retired-instruction count (WB_INSTRET_EN only)
// -----------------------------------------------------------------------------
module wb_stage
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_load_data,
    input  logic [2:0]      in_funct3,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_result,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wdata,
    output logic            misalign_err
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    stage_t          s;
    logic            md_last;
    logic            grant_md;
    logic            grant_in;
    logic [XLEN-1:0] ld_data;
    logic            ld_misaligned;
    logic            pipe_misaligned;
    logic [XLEN-1:0] pipe_data;

    load_align u_load_align (
        .word       (in_load_data),
        .offset     (in_alu_result[1:0]),
        .funct3     (in_funct3),
        .data       (ld_data),
        .misaligned (ld_misaligned)
    );

    // Mul/div yields only when it won last time and the pipeline is waiting,
    // so two continuously valid sources strictly alternate.
    assign grant_md = !rst && md_valid && !(md_last && in_valid);
    assign grant_in = !rst && in_valid && !grant_md;
    assign in_ready = grant_in;
    assign md_ready = grant_md;

    assign pipe_misaligned = (in_wb_sel == WB_LOAD) && ld_misaligned;

    always_comb begin
        pipe_data = in_alu_result;
        case (in_wb_sel)
            WB_LOAD: pipe_data = ld_data;
            WB_PC4:  pipe_data = in_pc + 32'd4;
            default: pipe_data = in_alu_result;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data/rd are reset too (not just valid) so wb_rd/wb_wdata
            // stay deterministic while wb_we is low.
            s            <= '0;
            md_last      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= grant_in && pipe_misaligned;
            if (grant_md) begin
                s.valid <= 1'b1;
                s.we    <= (md_rd != 5'd0);
                s.rd    <= md_rd;
                s.data  <= md_result;
                md_last <= 1'b1;
            end else if (grant_in) begin
                s.valid <= 1'b1;
                s.we    <= in_reg_write && (in_rd != 5'd0) && !pipe_misaligned;
                s.rd    <= in_rd;
                s.data  <= pipe_data;
                md_last <= 1'b0;
            end else begin
                s.valid <= 1'b0;
            end
        end
    end

    assign wb_we    = s.valid && s.we;
    assign wb_rd    = s.rd;
    assign wb_wdata = s.data;

`ifdef WB_INSTRET_EN
    // Counts every pipeline retirement, including non-writing and dropped ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= 64'd0;
        end else if (grant_in) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed vector table, hand-written
// arbitration/reset sequences, and randomized traffic against a reference
// model. Build with or without WB_INSTRET_EN.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [31:0] in_load_data;
    logic [2:0]  in_funct3;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        misalign_err;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit          ref_prev_md = 1'b0;
    longint unsigned ref_instret = 0;

    wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc         (in_pc),
        .in_load_data  (in_load_data),
        .in_funct3     (in_funct3),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_rd         (md_rd),
        .md_result     (md_result),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_wdata      (wb_wdata),
        .misalign_err  (misalign_err)
`ifdef WB_INSTRET_EN
        ,
        .instret       (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Size-based alignment rule: an access of N bytes must sit on an N-byte boundary.
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input logic [2:0] f3);
        logic [31:0] w;
        w = word >> (off * 8);
        case (f3)
            3'b000:  return 32'($signed(w[7:0]));
            3'b001:  return 32'($signed(w[15:0]));
            3'b100:  return 32'(w[7:0]);
            3'b101:  return 32'(w[15:0]);
            default: return word;
        endcase
    endfunction

    // One clock of traffic. Entered at posedge+2 with inputs already driven;
    // returns at the next posedge+2 after checking the registered outputs.
    task automatic tick();
        bit          g_md, g_in, e_we, e_err;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        int          off;
        bit          mis;
        #2;
        if (md_valid && in_valid) g_md = !ref_prev_md;
        else                      g_md = md_valid;
        g_in = in_valid && !g_md;
        check("md_ready", 64'(md_ready), 64'(g_md));
        check("in_ready", 64'(in_ready), 64'(g_in));
        e_we = 0; e_err = 0; e_rd = 0; e_data = 0;
        if (g_md) begin
            e_we = (md_rd != 0); e_rd = md_rd; e_data = md_result;
        end else if (g_in) begin
            off = int'(in_alu_result[1:0]);
            mis = (in_wb_sel == 2'd1) && ((off % ref_size(in_funct3)) != 0);
            e_err = mis;
            e_we  = in_reg_write && (in_rd != 0) && !mis;
            e_rd  = in_rd;
            if (in_wb_sel == 2'd1)      e_data = ref_load(in_load_data, off, in_funct3);
            else if (in_wb_sel == 2'd2) e_data = in_pc + 32'd4;
            else                        e_data = in_alu_result;
            ref_instret++;
        end
        if (g_md || g_in) ref_prev_md = g_md;
        @(posedge clk);
        #2;
        check("wb_we", 64'(wb_we), 64'(e_we));
        if (e_we) begin
            check("wb_rd", 64'(wb_rd), 64'(e_rd));
            check("wb_wdata", 64'(wb_wdata), 64'(e_data));
        end
        check("misalign_err", 64'(misalign_err), 64'(e_err));
`ifdef WB_INSTRET_EN
        check("instret", instret, 64'(ref_instret));
`endif
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_reg_write = 0; in_rd = 0; in_wb_sel = 0;
        in_alu_result = 0; in_pc = 0; in_load_data = 0; in_funct3 = 0;
        md_valid = 0; md_rd = 0; md_result = 0;
    endtask

    typedef struct {
        string       name;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] ld;
        logic [2:0]  f3;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Directed pipeline vectors with hand-derived expected results.
        vecs.push_back('{"lb_off3",   1, 5, 2'd1, 32'h0000_1003, 0, 32'h80FF_1234, 3'b000, 1, 32'hFFFF_FF80, 0});
        vecs.push_back('{"lhu_off2",  1, 6, 2'd1, 32'h0000_2002, 0, 32'hBEEF_0000, 3'b101, 1, 32'h0000_BEEF, 0});
        vecs.push_back('{"lh_off1",   1, 7, 2'd1, 32'h0000_2001, 0, 32'hBEEF_0000, 3'b001, 0, 32'h0,         1});
        vecs.push_back('{"alu_x0",    1, 0, 2'd0, 32'h0000_1234, 0, 32'h0,         3'b010, 0, 32'h0,         0});
        vecs.push_back('{"pc4_wrap",  1, 1, 2'd2, 32'h0,  32'hFFFF_FFFC, 32'h0,    3'b010, 1, 32'h0,         0});
        vecs.push_back('{"lw_off0",   1, 8, 2'd1, 32'h0000_3000, 0, 32'hDEAD_BEEF, 3'b010, 1, 32'hDEAD_BEEF, 0});
        vecs.push_back('{"lw_off2",   1, 8, 2'd1, 32'h0000_3002, 0, 32'hDEAD_BEEF, 3'b010, 0, 32'h0,         1});
        vecs.push_back('{"f3u_off0",  1, 9, 2'd1, 32'h0000_3000, 0, 32'h1234_5678, 3'b011, 1, 32'h1234_5678, 0});
        vecs.push_back('{"f3u_off1",  1, 9, 2'd1, 32'h0000_3001, 0, 32'h1234_5678, 3'b111, 0, 32'h0,         1});
        vecs.push_back('{"lbu_off1",  1, 10, 2'd1, 32'h0000_4001, 0, 32'h0000_8000, 3'b100, 1, 32'h0000_0080, 0});
        vecs.push_back('{"lh_off2",   1, 11, 2'd1, 32'h0000_4002, 0, 32'h8001_0000, 3'b001, 1, 32'hFFFF_8001, 0});
        vecs.push_back('{"sel3_alu",  1, 12, 2'd3, 32'h0000_0055, 32'h100, 32'h0,  3'b000, 1, 32'h0000_0055, 0});
        vecs.push_back('{"no_write",  0, 13, 2'd0, 32'h0000_0077, 0, 32'h0,        3'b000, 0, 32'h0,         0});
        vecs.push_back('{"lh_off1_ng",0, 14, 2'd2, 32'h0000_0001, 32'h10, 32'h0,   3'b001, 0, 32'h0,         0});

        // Reset state, with both sources requesting: grants must stay low.
        idle_inputs();
        rst = 1;
        in_valid = 1; md_valid = 1;
        #1;
        check("rst_wb_we", 64'(wb_we), 0);
        check("rst_wb_rd", 64'(wb_rd), 0);
        check("rst_wb_wdata", 64'(wb_wdata), 0);
        check("rst_misalign", 64'(misalign_err), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_md_ready", 64'(md_ready), 0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 0);
`endif
        repeat (2) @(posedge clk);
        #2;
        rst = 0;

        // Both valid for 4 cycles from reset: md, pipe, md, pipe.
        in_rd = 5'd3; in_reg_write = 1; in_alu_result = 32'h0000_00AA;
        md_rd = 5'd4; md_result = 32'h0000_0BBB;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("alt_in_ready", 64'(in_ready), 64'(i % 2));
            #(-0);
            tick_wrapper();
        end
`ifdef WB_INSTRET_EN
        check("alt_instret", instret, 2);
`endif

        // Directed table: each entry alone, followed by an idle cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            idle_inputs();
            in_valid      = 1;
            in_reg_write  = vecs[i].reg_write;
            in_rd         = vecs[i].rd;
            in_wb_sel     = vecs[i].wb_sel;
            in_alu_result = vecs[i].alu;
            in_pc         = vecs[i].pc;
            in_load_data  = vecs[i].ld;
            in_funct3     = vecs[i].f3;
            tick();
            check({vecs[i].name, "_we"}, 64'(wb_we), 64'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check({vecs[i].name, "_rd"}, 64'(wb_rd), 64'(vecs[i].rd));
                check({vecs[i].name, "_data"}, 64'(wb_wdata), 64'(vecs[i].exp_data));
            end
            check({vecs[i].name, "_err"}, 64'(misalign_err), 64'(vecs[i].exp_err));
            idle_inputs();
            tick();
        end

        // Mid-cycle reset while S holds a valid write.
        idle_inputs();
        in_valid = 1; in_reg_write = 1; in_rd = 5'd17; in_alu_result = 32'h0000_5A5A;
        tick();
        check("pre_rst_we", 64'(wb_we), 1);
        rst = 1;
        #1;
        check("async_rst_we", 64'(wb_we), 0);
        check("async_rst_grant", 64'(in_ready), 0);
        ref_prev_md = 0;
        ref_instret = 0;
        @(posedge clk);
        #2;
        check("held_rst_we", 64'(wb_we), 0);
        rst = 0;
        // Pipeline won last before reset; md_last must be back to 0 so md wins.
        md_valid = 1; md_rd = 5'd21; md_result = 32'hCAFE_0001;
        #1;
        check("post_rst_md_first", 64'(md_ready), 1);
        #1;
        tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            md_valid      = ($urandom_range(0, 2) == 0);
            in_reg_write  = ($urandom_range(0, 4) != 0);
            in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_wb_sel     = 2'($urandom);
            in_alu_result = $urandom;
            in_pc         = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            in_load_data  = $urandom;
            in_funct3     = 3'($urandom);
            md_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            md_result     = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Aligns the 4-cycle alternation loop: its in_ready probe consumes 2 time
    // units, so step back onto the posedge+2 phase that tick() expects.
    task automatic tick_wrapper();
        bit          g_md, g_in;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        // Inputs are constant here and both valid: alternation starting with md.
        g_md = !ref_prev_md;
        g_in = !g_md;
        check("alt_md_ready", 64'(md_ready), 64'(g_md));
        e_rd   = g_md ? md_rd : in_rd;
        e_data = g_md ? md_result : in_alu_result;
        if (g_in) ref_instret++;
        ref_prev_md = g_md;
        @(posedge clk);
        #2;
        check("alt_wb_we", 64'(wb_we), 1);
        check("alt_wb_rd", 64'(wb_rd), 64'(e_rd));
        check("alt_wb_wdata", 64'(wb_wdata), 64'(e_data));
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
